// File: rtl/memory_sequencer.sv
// memory_sequencer: initiator for the memory control interface.
// Fetches 16-bit instructions as two byte reads at {PC,0} and {PC,1}, then
// increments PC. Also services execute-stage loads and stores through MAR,
// and applies PC jumps. It is the only driver of the memory control signals.
// Optional feature: define SEQ_BUSY_COUNT_EN to add the busy_cycles counter port.

package memory_sequencer_pkg;
    typedef enum logic [1:0] {
        MEM_NOP   = 2'd0,
        MEM_READ  = 2'd1,
        MEM_WRITE = 2'd2
    } memory_op_e;

    typedef enum logic [2:0] {
        ADDR_NOP      = 3'd0,
        ADDR_REL_SUB  = 3'd1,
        ADDR_REL_ADD  = 3'd2,
        ADDR_INC      = 3'd3,
        ADDR_ABSOLUTE = 3'd4
    } address_reg_op_e;

    typedef enum logic {
        BUS_MAR = 1'b0,
        BUS_PC  = 1'b1
    } memory_bus_selector_e;
endpackage

module memory_sequencer
    import memory_sequencer_pkg::*;
#(
    parameter int READ_CYCLES    = 2,
    parameter bit FETCH_ON_RESET = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fetch_en,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [15:0]          instr,
    input  logic                 jump_valid,
    input  logic [1:0]           jump_mode,
    input  logic [7:0]           jump_operand,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [7:0]           req_addr,
    input  logic                 req_word,
    input  logic [7:0]           req_wdata,
    output logic                 req_ack,
    output logic [7:0]           rdata,
    output memory_op_e           mem_op,
    output address_reg_op_e      mem_addr_op,
    output memory_bus_selector_e mem_bus_sel,
    output logic                 mem_word_sel,
    output logic [7:0]           mem_wdata,
    input  logic [7:0]           mem_rdata
`ifdef SEQ_BUSY_COUNT_EN
    ,
    output logic [15:0]          busy_cycles
`endif
);

    localparam int CNT_W = $clog2(READ_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE,
        JUMP,
        D_SETMAR,
        D_READ,
        D_WRITE,
        D_ACK,
        F_HI,
        F_LO,
        F_INC,
        F_HOLD
    } state_e;

    state_e         state;
    logic [CNT_W-1:0] cnt;
    // Lets the first idle cycle after reset start a fetch without fetch_en.
    logic           boot_fetch;
    logic           cnt_last;

    assign cnt_last = (cnt == CNT_LAST);

    // Jump modes 0/1/2 map onto the memory's PC update ops; anything else is a no-op.
    function automatic address_reg_op_e jump_to_addr_op(input logic [1:0] mode);
        case (mode)
            2'd0:    return ADDR_ABSOLUTE;
            2'd1:    return ADDR_REL_ADD;
            2'd2:    return ADDR_REL_SUB;
            default: return ADDR_NOP;
        endcase
    endfunction

    // Sequencer FSM: every memory command is registered and aligned with its state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            boot_fetch   <= FETCH_ON_RESET;
            instr_valid  <= 1'b0;
            instr        <= 16'h0000;
            req_ack      <= 1'b0;
            rdata        <= 8'h00;
            mem_op       <= MEM_NOP;
            mem_addr_op  <= ADDR_NOP;
            mem_bus_sel  <= BUS_MAR;
            mem_word_sel <= 1'b0;
            mem_wdata    <= 8'h00;
        end else begin
            // Commands last exactly one cycle unless a state re-issues them.
            mem_op      <= MEM_NOP;
            mem_addr_op <= ADDR_NOP;
            req_ack     <= 1'b0;
            case (state)
                IDLE: begin
                    boot_fetch <= 1'b0;
                    if (jump_valid) begin
                        state       <= JUMP;
                        mem_bus_sel <= BUS_PC;
                        mem_addr_op <= jump_to_addr_op(jump_mode);
                        mem_wdata   <= jump_operand;
                    end else if (req_valid) begin
                        state       <= D_SETMAR;
                        mem_bus_sel <= BUS_MAR;
                        mem_addr_op <= ADDR_ABSOLUTE;
                        mem_wdata   <= req_addr;
                    end else if (fetch_en || boot_fetch) begin
                        state        <= F_HI;
                        mem_bus_sel  <= BUS_PC;
                        mem_op       <= MEM_READ;
                        mem_word_sel <= 1'b0;
                        cnt          <= '0;
                    end
                end
                JUMP: begin
                    state <= IDLE;
                end
                D_SETMAR: begin
                    mem_word_sel <= req_word;
                    cnt          <= '0;
                    if (req_write) begin
                        state     <= D_WRITE;
                        mem_op    <= MEM_WRITE;
                        mem_wdata <= req_wdata;
                    end else begin
                        state  <= D_READ;
                        mem_op <= MEM_READ;
                    end
                end
                D_READ: begin
                    if (cnt_last) begin
                        rdata   <= mem_rdata;
                        state   <= D_ACK;
                        req_ack <= 1'b1;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        mem_op <= MEM_READ;
                    end
                end
                D_WRITE: begin
                    state   <= D_ACK;
                    req_ack <= 1'b1;
                end
                D_ACK: begin
                    state <= IDLE;
                end
                F_HI: begin
                    if (cnt_last) begin
                        instr[15:8]  <= mem_rdata;
                        state        <= F_LO;
                        mem_op       <= MEM_READ;
                        mem_word_sel <= 1'b1;
                        cnt          <= '0;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        mem_op <= MEM_READ;
                    end
                end
                F_LO: begin
                    if (cnt_last) begin
                        instr[7:0]  <= mem_rdata;
                        state       <= F_INC;
                        mem_addr_op <= ADDR_INC;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        mem_op <= MEM_READ;
                    end
                end
                F_INC: begin
                    state       <= F_HOLD;
                    instr_valid <= 1'b1;
                end
                F_HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_BUSY_COUNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Count every non-idle cycle, sticking at the top value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_cycles <= 16'h0000;
        end else if (state != IDLE) begin
            busy_cycles <= sat_inc(busy_cycles);
        end
    end
`endif

endmodule
